// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - segment encodings and hex-to-segment helper
package seven_seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble, input logic dp);
    return {~dp, SEG_LUT[nibble]};
  endfunction

endpackage

// File: rtl/seven_seg_encoder.sv
// rtl/seven_seg_encoder.sv - combinational nibble + dp to active-low segment byte
module seven_seg_encoder (
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] sseg
);
  import seven_seg_pkg::*;

  assign sseg = hex_to_seg(nibble, dp);

endmodule

// File: rtl/seven_seg_mux_driver.sv
// rtl/seven_seg_mux_driver.sv - time-multiplexed N-digit seven-segment driver
module seven_seg_mux_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [7:0]              sseg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  import seven_seg_pkg::*;

  localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  logic [PRESC_W-1:0]      presc;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pend_value, act_value;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic [NUM_DIGITS-1:0]   suppress;
  logic                    tick, wrap_tick, in_blank, dark;
  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic [7:0]              cur_seg;

  assign tick      = (presc == PRESC_MAX);
  assign wrap_tick = tick && (idx == IDX_MAX);

  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      assign in_blank = (presc < PRESC_W'(BLANK_CYCLES));
    end else begin : g_no_blank
      assign in_blank = 1'b0;
    end
  endgenerate

  // A digit is suppressed when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    suppress = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      suppress[i] = lz_blank;
      for (int j = i; j < NUM_DIGITS; j++) begin
        if (act_value[4*j +: 4] != 4'h0) suppress[i] = 1'b0;
      end
    end
  end

  assign cur_nibble = act_value[4*idx +: 4];
  assign cur_dp     = act_dp[idx];
  assign dark       = !digit_en[idx] || suppress[idx] || in_blank;

  seven_seg_encoder u_encoder (
    .nibble (cur_nibble),
    .dp     (cur_dp),
    .sseg   (cur_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      pend_value <= '0;
      pend_dp    <= '0;
      act_value  <= '0;
      act_dp     <= '0;
      an         <= '1;
      sseg       <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;

      if (load) begin
        pend_value <= value;
        pend_dp    <= dp;
      end
      // Swap only at the frame boundary so a frame never mixes old and new digits.
      if (wrap_tick) begin
        act_value <= load ? value : pend_value;
        act_dp    <= load ? dp : pend_dp;
      end

      frame_done <= wrap_tick;
      an         <= dark ? '1 : ~(NUM_DIGITS'(1) << idx);
      sseg       <= dark ? SEG_BLANK : cur_seg;
    end
  end

endmodule

// File: doc/seven_seg_mux_driver.md
Name: seven_seg_mux_driver

Overview:
Time-multiplexed N-digit seven-segment display driver. Holds a double-buffered hex value, scans one digit per refresh slot and drives shared active-low segment lines plus per-digit active-low anodes. Adds anti-ghosting dead time, per-digit enables, leading-zero suppression and tear-free updates at frame boundaries. Sits between CPU output registers and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (legal 1..8)
REFRESH_DIV, 100000, clk cycles per digit slot (legal >= 2)
BLANK_CYCLES, 2000, cycles at the start of each slot with all anodes off (legal 0..REFRESH_DIV-1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
value  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) shown on digit i; digit 0 is rightmost
dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
digit_en  in  NUM_DIGITS  1 = digit may be driven; 0 = digit held dark
lz_blank  in  1  1 = suppress leading zeros
load  in  1  single-cycle strobe capturing value and dp into the pending buffer
sseg  out  8  {dp,g,f,e,d,c,b,a}, active-low (0 = segment lit)
an  out  NUM_DIGITS  digit anodes, active-low (0 = digit on)
frame_done  out  1  one-cycle pulse after the last digit slot of each frame

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (rst_n).
- Reset (async assert, sync release): prescaler=0, digit index=0, pending and active buffers=0, an=all 1s, sseg=8'hFF, frame_done=0. Takes effect immediately, including mid-frame.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. Width $clog2(REFRESH_DIV). tick = (prescaler==REFRESH_DIV-1).
- Digit index: advances on tick, wraps NUM_DIGITS-1 -> 0. Wrap tick = frame boundary; frame_done asserts in the cycle after the wrap tick.
- Frame period: NUM_DIGITS*REFRESH_DIV cycles.
- Buffering: load captures value and dp into pending. active <= pending only on a frame boundary. If load and the frame boundary fall in the same cycle, active takes the incoming value directly. Multiple loads within a frame: last one wins.
- Encoding of nibble to {g..a}, 0 = lit: 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0011000, A:0001000, B:0000011, C:1000110, D:0100001, E:0000110, F:0001110. sseg[7] = ~dp[i].
- Leading-zero suppression (lz_blank=1): scan from digit NUM_DIGITS-1 down. Suppress each digit whose active nibble is 0 until the first nonzero digit is reached. Digit 0 is never suppressed. Evaluated on the active buffer only.
- Digit dark condition: digit_en[i]=0, or the digit is suppressed, or prescaler < BLANK_CYCLES. When dark, the digit's anode is 1 and sseg=8'hFF.
- Lit condition: exactly one anode is 0 (the current index) and sseg = encoding of that digit.
- Outputs are registered: an and sseg reflect prescaler, index and active buffer state from the previous cycle (latency 1).
- Inputs other than load are sampled whenever used. The async inputs value and dp are not synchronised; the source must be in the clk domain.

Decomposition:
- Package seven_seg_pkg: 16-entry segment encoding constants, SEG_BLANK=8'hFF, and function hex_to_seg(nibble, dp) returning 8 bits.
- One combinational sub-module, seven_seg_encoder (nibble, dp -> sseg), wrapping the package function so other display blocks reuse it.
- Prescaler, scan index, buffers, suppression logic and output registers live in the top module.

Test Plan:
(All scenarios: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.)
1. Reset: assert rst_n=0 mid-simulation -> an=4'hF, sseg=8'hFF, frame_done=0 immediately. After release, frame_done pulses every 16 cycles.
2. Digit scan: load value=16'h1234, dp=0, digit_en=4'hF, lz_blank=0; wait for a frame boundary. Digit 0 slot: an=4'b1110, sseg=8'h99. Digit 1: 4'b1101/8'hB0. Digit 2: 4'b1011/8'hA4. Digit 3: 4'b0111/8'hF9. The first cycle of each slot is an=4'hF, sseg=8'hFF.
3. Leading-zero suppression: lz_blank=1.
   - value=16'h0050: digits 3 and 2 dark; digit 1 sseg=8'h92; digit 0 sseg=8'hC0.
   - value=16'h0000: only digit 0 lit, sseg=8'hC0.
4. Per-digit enable and dp: digit_en=4'b0101, dp=4'b0001, value=16'h8888. an[1] and an[3] never 0; digit 0 sseg=8'h00; digit 2 sseg=8'h80.
5. Buffering: load 16'hAAAA mid-frame -> display unchanged until the next frame boundary, then 8'h88 on all digits. A load of 16'hFFFF coincident with the wrap tick -> 8'h8E on digit 0 of the next frame.
6. Reset mid-operation: deassert rst_n during a digit-2 slot -> outputs dark at once. After release, the scan restarts at digit 0 showing 8'hC0 once the reset-cleared active buffer is displayed.
